// File: rtl/uart_pkg.sv
// Shared types and helpers for the duty-setting UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  localparam int unsigned OVS_DEFAULT = 16;

  // Clocks per oversample tick, truncated and never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    int unsigned d;
    d = clk_freq / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-clock oversample tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      TICK <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      TICK <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_duty.sv
// 8-bit UART receiver whose good frames also load a held PWM duty value.
// Define UART_RX_DUTY_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_duty
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned OVS      = OVS_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       FRAME_ERR,
  output logic [7:0] DUTY
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int unsigned PW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [PW-1:0] HALF_LAST = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] FULL_LAST = PW'(OVS - 1);

  logic          sync1, sync2;
  logic          tick;
  state_t        state;
  logic [PW-1:0] phase;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_ok_c;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

`ifdef UART_RX_DUTY_PARITY_EN
  logic par_err;
  assign stop_ok_c = sync2 & ~par_err;
`else
  assign stop_ok_c = sync2;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= ST_IDLE;
      phase      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      DATA       <= '0;
      DUTY       <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
`ifdef UART_RX_DUTY_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      sync1      <= RX;
      sync2      <= sync1;
      DATA_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sync2) begin
            state <= ST_START;
            phase <= '0;
          end
        end
        // Re-check the start bit at its centre to reject short glitches.
        ST_START: begin
          if (tick) begin
            if (phase == HALF_LAST) begin
              phase   <= '0;
              bit_idx <= '0;
              state   <= sync2 ? ST_IDLE : ST_DATA;
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (phase == FULL_LAST) begin
              phase   <= '0;
              shreg   <= {sync2, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_DUTY_PARITY_EN
              if (bit_idx == 3'd7) state <= ST_PARITY;
`else
              if (bit_idx == 3'd7) state <= ST_STOP;
`endif
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
`ifdef UART_RX_DUTY_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (phase == FULL_LAST) begin
              phase   <= '0;
              par_err <= sync2 ^ (^shreg);
              state   <= ST_STOP;
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (phase == FULL_LAST) begin
              phase <= '0;
              if (stop_ok_c) begin
                DATA       <= shreg;
                DUTY       <= shreg;
                DATA_VALID <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                FRAME_ERR <= 1'b1;
                state     <= sync2 ? ST_IDLE : ST_WAIT_IDLE;
              end
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
        // A held-low line (break) must return high for a full bit before rearming.
        ST_WAIT_IDLE: begin
          if (!sync2) begin
            phase <= '0;
          end else if (tick) begin
            if (phase == FULL_LAST) begin
              phase <= '0;
              state <= ST_IDLE;
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_duty.sv
// Self-checking bench for uart_rx_duty: vector table, directed corner sequences, random frames.
module tb_uart_rx_duty;

  localparam int unsigned DIV = 27;
  localparam int unsigned OVS = 16;
  localparam int unsigned BIT = DIV * OVS;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic [7:0] duty;
  logic       data_valid;
  logic       frame_err;

  int cmps = 0;
  int errs = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;

  always #5 clk = ~clk;

  uart_rx_duty #(.CLK_FREQ(50000000), .BAUD(115200), .OVS(OVS)) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX         (rx),
    .DATA       (data),
    .DATA_VALID (data_valid),
    .FRAME_ERR  (frame_err),
    .DUTY       (duty)
  );

  // Count pulse-high cycles away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) vcnt++;
      if (frame_err) ecnt++;
      if (data_valid && frame_err) both++;
    end
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_DUTY_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_RX_DUTY_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  // Send one frame, let it settle, compare pulse counts and held outputs.
  task automatic frame_check(input string tag, input logic [7:0] b, input logic stop_bit,
                             input int gap, input int exp_v, input int exp_e,
                             input logic [7:0] exp_data, input logic [7:0] exp_duty);
    int v0, e0;
    v0 = vcnt;
    e0 = ecnt;
    send_frame(b, stop_bit);
    idle_bits(gap);
    check({tag, "_valid_cnt"}, 32'(vcnt - v0), 32'(exp_v));
    check({tag, "_err_cnt"}, 32'(ecnt - e0), 32'(exp_e));
    check({tag, "_data"}, 32'(data), 32'(exp_data));
    check({tag, "_duty"}, 32'(duty), 32'(exp_duty));
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       stop;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_data;
    logic [7:0] exp_duty;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int v0, e0;
    logic [7:0] m_data, m_duty, b;
    logic stop_bit;
    logic [7:0] b55;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5, 8'hA5};
    vecs[2] = '{8'h10, 1'b1, 1, 0, 8'h10, 8'h10};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_duty", 32'(duty), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    rst = 1'b0;
    idle_bits(2);

    for (int i = 0; i < 3; i++)
      frame_check($sformatf("vec%0d", i), vecs[i].byte_v, vecs[i].stop, 2,
                  vecs[i].exp_v, vecs[i].exp_e, vecs[i].exp_data, vecs[i].exp_duty);

    // Five-tick low glitch must be rejected silently.
    v0 = vcnt;
    e0 = ecnt;
    rx = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    idle_bits(2);
    check("glitch_valid_cnt", 32'(vcnt - v0), 32'h0);
    check("glitch_err_cnt", 32'(ecnt - e0), 32'h0);
    check("glitch_duty", 32'(duty), 32'h10);

    // Back-to-back frames with no idle gap.
    v0 = vcnt;
    e0 = ecnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(2);
    check("b2b_valid_cnt", 32'(vcnt - v0), 32'h2);
    check("b2b_err_cnt", 32'(ecnt - e0), 32'h0);
    check("b2b_data", 32'(data), 32'hFF);
    check("b2b_duty", 32'(duty), 32'hFF);

    // Reset in the middle of bit 4 of 0x55, then a clean 0x55.
    b55 = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b55[i]);
    rx = b55[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_duty", 32'(duty), 32'h0);
    check("midrst_valid", 32'(data_valid), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    frame_check("post_rst", 8'h55, 1'b1, 2, 1, 0, 8'h55, 8'h55);

`ifdef UART_RX_DUTY_PARITY_EN
    v0 = vcnt;
    e0 = ecnt;
    send_frame_par(8'h07, 1'b0);
    idle_bits(2);
    check("par_bad_err_cnt", 32'(ecnt - e0), 32'h1);
    check("par_bad_valid_cnt", 32'(vcnt - v0), 32'h0);
    check("par_bad_duty", 32'(duty), 32'h55);
    v0 = vcnt;
    e0 = ecnt;
    send_frame_par(8'h07, 1'b1);
    idle_bits(2);
    check("par_good_valid_cnt", 32'(vcnt - v0), 32'h1);
    check("par_good_err_cnt", 32'(ecnt - e0), 32'h0);
    check("par_good_data", 32'(data), 32'h07);
`endif

    // Random frames against a last-good-byte model.
    m_data = data;
    m_duty = duty;
    for (int i = 0; i < 6; i++) begin
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      if (stop_bit) begin
        m_data = b;
        m_duty = b;
      end
      frame_check($sformatf("rnd%0d", i), b, stop_bit, 2 + int'($urandom_range(0, 1)),
                  stop_bit ? 1 : 0, stop_bit ? 0 : 1, m_data, m_duty);
    end

    check("pulse_overlap", 32'(both), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
